l2cache_assoc: RTL and testbench
================================

# l2cache_assoc

Parametrised set-associative, write-back, write-allocate L2 cache between the L1 caches and main memory. Generalises the current 8×8 L2 to configurable sets, ways and line width. Adds victim selection that advances only on fills, write-miss install without a memory fetch, and saturating hit/miss counters. Line-granular on both sides: one request moves one full DATA_W line.

## Interface
- ADDR_W, 28, line address width (cache_addr/mem_addr)
- DATA_W, 128, line width in bits
- SETS, 8, number of sets (power of two, ≥2); IDX_W = log2(SETS)
- WAYS, 8, ways per set (power of two, ≥2); WAY_W = log2(WAYS)
- CNT_W, 32, width of statistics counters
- clk  in  1  clock; all state changes on rising edge
- cache_reset_n  in  1  asynchronous, active-low reset
- cache_read  in  1  read request, held until cache_ready
- cache_write  in  1  write request, held until cache_ready
- cache_addr  in  ADDR_W  line address; index = [IDX_W-1:0], tag = [ADDR_W-1:IDX_W]
- cache_wdata  in  DATA_W  write line
- cache_ready  out  1  one-cycle completion pulse, registered
- cache_rdata  out  DATA_W  read line, valid while cache_ready=1
- mem_read  out  1  memory read request, registered
- mem_write  out  1  memory write request, registered
- mem_addr  out  ADDR_W  memory line address, registered
- mem_wdata  out  DATA_W  writeback line, registered
- mem_rdata  in  DATA_W  fill line, valid with mem_ready
- mem_ready  in  1  one-cycle memory completion pulse
- hit_count  out  CNT_W  saturating count of completed hits
- miss_count  out  CNT_W  saturating count of misses

## Operation
- Storage per set/way: data, tag (ADDR_W-IDX_W bits), valid, dirty. Per set: victim pointer vptr (WAY_W bits).
- Hit: valid && tag match in the indexed set; lowest matching way wins (duplicates must not arise).
- Request legal only when exactly one of cache_read/cache_write is high; both high or both low is no request and is ignored.
- States: IDLE, DONE, WB, FILL.
- IDLE, legal request, hit: read latches way data into cache_rdata; write stores cache_wdata, sets dirty. -> DONE; hit_count+1.
- IDLE, miss: miss_count+1. Victim = first invalid way in set, else way vptr. Victim valid&&dirty -> WB; else read -> FILL; else (write) install directly: data=cache_wdata, tag, valid=1, dirty=1, vptr+1 mod WAYS -> DONE.
- WB: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ready: victim dirty=0, valid=0; read -> FILL; write -> install as above -> DONE.
- FILL: mem_read=1, mem_addr=cache_addr. On mem_ready: data=mem_rdata, tag, valid=1, dirty=0, vptr+1 mod WAYS -> IDLE. The re-lookup then hits and counts as a hit.
- DONE: cache_ready=1 for exactly one cycle -> IDLE. Requester drops or changes its request on the cycle after cache_ready.
- vptr advances only on install, never on hits.
- Counters saturate at 2^CNT_W-1.

## Timing
- Reset (async assert, sync release) clears all valid/dirty/tag/data, vptr, counters, and state to IDLE. cache_ready, mem_read, mem_write, mem_addr, mem_wdata, cache_rdata are all 0.
- Reset mid-WB/FILL drops mem_read/mem_write immediately. The in-flight mem_ready is ignored.
- Read or write hit: request at cycle N (IDLE) -> cache_ready at N+1 -> IDLE at N+2. Back-to-back hits complete every 2 cycles.
- Clean read miss: FILL entered at N+1. mem_read high from N+1 until the cycle after mem_ready (edge M). IDLE at M+1, cache_ready at M+2.
- Dirty read miss: WB then FILL; mem_write and mem_read are never high together.
- Clean write miss: cache_ready at N+1, no memory traffic.
- mem_addr/mem_wdata stable for the entire time mem_read/mem_write is high.
- mem_ready while neither mem_read nor mem_write is high is ignored.

## Test plan
- Reset; read 0x0000010 -> mem_read with mem_addr=0x0000010; mem_rdata=0xA5…A5 -> cache_ready with rdata=0xA5…A5; miss_count=1, hit_count=1.
- Repeat read 0x0000010 -> cache_ready exactly 1 cycle after request, no mem traffic, hit_count=2.
- Write 0x0000018 with 0x1234 (clean miss) -> no mem traffic, cache_ready at N+1; read back returns 0x1234.
- Fill all 8 ways of set 0 with dirty writes (tags 1..8), then read tag 9 set 0 -> mem_write of way 0 line at {tag1,0}, then mem_read; vptr=1 afterwards.
- Assert cache_read and cache_write together for 10 cycles -> no cache_ready, no mem traffic, counters unchanged.
- Drop cache_reset_n during FILL -> mem_read falls asynchronously; later read of the same address misses again.

Source files
------------

// File: rtl/l2cache_assoc.sv
// Set-associative write-back/write-allocate L2 cache, one full line per request.
// Victim choice: first invalid way, else a per-set round-robin pointer that moves only on installs.
module l2cache_assoc #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int SETS   = 8,
    parameter int WAYS   = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              cache_reset_n,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [DATA_W-1:0] cache_wdata,
    output logic              cache_ready,
    output logic [DATA_W-1:0] cache_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, DONE, WB, FILL} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  vptr_q  [SETS];
    logic [WAY_W-1:0]  vway_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             req;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] ins_way;

    logic hit_ev, miss_ev, start_wb, start_fill, wb_clr, ins_wr, ins_fill;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign idx = cache_addr[IDX_W-1:0];
    assign tag = cache_addr[ADDR_W-1:IDX_W];
    assign req = cache_read ^ cache_write;

    // Descending scan so the lowest-numbered matching/invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim  = inv_found ? inv_way : vptr_q[idx];
    assign ins_way = (state_q == IDLE) ? victim : vway_q;

    always_ff @(posedge clk or negedge cache_reset_n) begin
        if (!cache_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hit_ev     = 1'b0;
        miss_ev    = 1'b0;
        start_wb   = 1'b0;
        start_fill = 1'b0;
        wb_clr     = 1'b0;
        ins_wr     = 1'b0;
        ins_fill   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        hit_ev  = 1'b1;
                        state_d = DONE;
                    end else begin
                        miss_ev = 1'b1;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            start_wb = 1'b1;
                            state_d  = WB;
                        end else if (cache_read) begin
                            start_fill = 1'b1;
                            state_d    = FILL;
                        end else begin
                            ins_wr  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            WB: begin
                if (mem_ready) begin
                    wb_clr = 1'b1;
                    if (cache_read) begin
                        start_fill = 1'b1;
                        state_d    = FILL;
                    end else begin
                        ins_wr  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            FILL: begin
                if (mem_ready) begin
                    ins_fill = 1'b1;
                    state_d  = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cache_reset_n) begin
        if (!cache_reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    data_q[s][w] <= '0;
                    tag_q[s][w]  <= '0;
                end
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
            vway_q      <= '0;
            cache_ready <= 1'b0;
            cache_rdata <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            cache_ready <= (state_d == DONE);

            if (hit_ev) begin
                hit_count <= sat_inc(hit_count);
                if (cache_read) begin
                    cache_rdata <= data_q[idx][hit_way];
                end else begin
                    data_q[idx][hit_way]  <= cache_wdata;
                    dirty_q[idx][hit_way] <= 1'b1;
                end
            end

            if (miss_ev) begin
                miss_count <= sat_inc(miss_count);
                vway_q     <= victim;
            end

            if (start_wb) begin
                mem_write <= 1'b1;
                mem_addr  <= {tag_q[idx][victim], idx};
                mem_wdata <= data_q[idx][victim];
            end

            if (wb_clr) begin
                mem_write            <= 1'b0;
                valid_q[idx][vway_q] <= 1'b0;
                dirty_q[idx][vway_q] <= 1'b0;
            end

            if (start_fill) begin
                mem_read <= 1'b1;
                mem_addr <= cache_addr;
            end

            // A write install after writeback targets the same way, so it overrides the clear above.
            if (ins_wr) begin
                data_q[idx][ins_way]  <= cache_wdata;
                tag_q[idx][ins_way]   <= tag;
                valid_q[idx][ins_way] <= 1'b1;
                dirty_q[idx][ins_way] <= 1'b1;
                vptr_q[idx]           <= vptr_q[idx] + WAY_W'(1);
            end

            if (ins_fill) begin
                mem_read             <= 1'b0;
                data_q[idx][vway_q]  <= mem_rdata;
                tag_q[idx][vway_q]   <= tag;
                valid_q[idx][vway_q] <= 1'b1;
                dirty_q[idx][vway_q] <= 1'b0;
                vptr_q[idx]          <= vptr_q[idx] + WAY_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_l2cache_assoc.sv
// Directed bench for l2cache_assoc: expected read data and memory transactions are queued
// when a request is issued and checked when the cache or memory side responds.
module tb_l2cache_assoc;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              cache_reset_n;
    logic              cache_read, cache_write;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wdata;
    logic              cache_ready;
    logic [DATA_W-1:0] cache_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  hit_count, miss_count;

    l2cache_assoc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(8), .WAYS(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .cache_reset_n(cache_reset_n),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_ready(cache_ready), .cache_rdata(cache_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mop_t;

    mop_t              mq[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];

    int                n_assert = 0;
    int                n_fail   = 0;
    bit                pending  = 0;
    int                wcnt     = 0;
    logic [ADDR_W-1:0] cap_addr;
    bit                cap_wr;

    function automatic logic [DATA_W-1:0] def_line(input logic [ADDR_W-1:0] a);
        return {4{32'hC0DE_0000 | {4'h0, a}}};
    endfunction

    function automatic logic [DATA_W-1:0] dline(input int t);
        return {4{32'h1000_0000 + 32'(t)}};
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_mop(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mop_t e;
        e.wr = wr; e.addr = a; e.data = d;
        mq.push_back(e);
    endtask

    // Memory responder, called once per negedge: checks new requests, answers after two cycles.
    task automatic mem_cycle();
        mop_t e;
        mem_ready = 1'b0;
        chk("mem_excl", 128'(mem_read & mem_write), 128'(0));
        if (pending) begin
            wcnt++;
            if (wcnt == 2) begin
                chk("mem_addr_stable", 128'(mem_addr), 128'(cap_addr));
                if (cap_wr) mem_model[cap_addr] = mem_wdata;
                else mem_rdata = mem_model.exists(cap_addr) ? mem_model[cap_addr] : def_line(cap_addr);
                mem_ready = 1'b1;
                pending   = 0;
            end
        end else if (mem_read || mem_write) begin
            if (mq.size() == 0) begin
                chk("unexpected_mem_req", 128'({mem_read, mem_write}), 128'(0));
            end else begin
                e = mq.pop_front();
                chk("mem_op_kind", 128'(mem_write), 128'(e.wr));
                chk("mem_addr", 128'(mem_addr), 128'(e.addr));
                if (e.wr) chk("mem_wdata", mem_wdata, e.data);
            end
            pending  = 1;
            wcnt     = 0;
            cap_addr = mem_addr;
            cap_wr   = mem_write;
        end
    endtask

    task automatic do_req(input string tag, input bit rd, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input int exp_k);
        bit got = 0;
        int k   = 0;
        cache_read  = rd;
        cache_write = !rd;
        cache_addr  = a;
        cache_wdata = wd;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            mem_cycle();
            if (cache_ready) begin
                got = 1;
                k   = i;
                break;
            end
        end
        chk({tag, "_ready"}, 128'(got), 128'(1));
        if (got && exp_k >= 0) chk({tag, "_latency"}, 128'(k), 128'(exp_k));
        if (got && rd && rd_q.size() > 0) chk({tag, "_rdata"}, cache_rdata, rd_q.pop_front());
        cache_read  = 1'b0;
        cache_write = 1'b0;
        @(negedge clk);
        mem_cycle();
        chk({tag, "_ready_pulse"}, 128'(cache_ready), 128'(0));
        chk({tag, "_memops_done"}, 128'(mq.size()), 128'(0));
    endtask

    task automatic apply_reset();
        cache_reset_n = 1'b0;
        cache_read    = 1'b0;
        cache_write   = 1'b0;
        mem_ready     = 1'b0;
        pending       = 0;
        repeat (2) @(negedge clk);
        cache_reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cache_reset_n = 1'b0;
        cache_read    = 1'b0;
        cache_write   = 1'b0;
        cache_addr    = '0;
        cache_wdata   = '0;
        mem_rdata     = '0;
        mem_ready     = 1'b0;
        mem_model[28'h10] = {16{8'hA5}};
        repeat (2) @(negedge clk);
        chk("rst_cache_ready", 128'(cache_ready), 128'(0));
        chk("rst_mem_read", 128'(mem_read), 128'(0));
        chk("rst_mem_write", 128'(mem_write), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        chk("rst_cache_rdata", cache_rdata, 128'(0));
        chk("rst_hit_count", 128'(hit_count), 128'(0));
        chk("rst_miss_count", 128'(miss_count), 128'(0));
        cache_reset_n = 1'b1;
        @(negedge clk);

        // Clean read miss, fill, re-lookup hit
        push_mop(0, 28'h10, '0);
        rd_q.push_back({16{8'hA5}});
        do_req("rd_miss_10", 1, 28'h10, '0, 5);
        chk("cnt1_miss", 128'(miss_count), 128'(1));
        chk("cnt1_hit", 128'(hit_count), 128'(1));

        rd_q.push_back({16{8'hA5}});
        do_req("rd_hit_10", 1, 28'h10, '0, 1);
        chk("cnt2_hit", 128'(hit_count), 128'(2));

        // Clean write miss installs without memory traffic
        do_req("wr_miss_18", 0, 28'h18, 128'h1234, 1);
        rd_q.push_back(128'h1234);
        do_req("rd_hit_18", 1, 28'h18, '0, 1);
        chk("cnt3_miss", 128'(miss_count), 128'(2));
        chk("cnt3_hit", 128'(hit_count), 128'(3));

        // Fill set 0 with dirty lines, then force evictions through the victim pointer
        apply_reset();
        chk("rst2_miss", 128'(miss_count), 128'(0));
        for (int t = 1; t <= 8; t++) do_req("wr_fill_set0", 0, ADDR_W'(t << 3), dline(t), 1);
        chk("cnt4_miss", 128'(miss_count), 128'(8));
        push_mop(1, 28'h08, dline(1));
        push_mop(0, 28'h48, '0);
        rd_q.push_back(def_line(28'h48));
        do_req("rd_evict_way0", 1, 28'h48, '0, -1);
        push_mop(1, 28'h10, dline(2));
        push_mop(0, 28'h50, '0);
        rd_q.push_back(def_line(28'h50));
        do_req("rd_evict_way1", 1, 28'h50, '0, -1);
        push_mop(1, 28'h18, dline(3));
        push_mop(0, 28'h08, '0);
        rd_q.push_back(dline(1));
        do_req("rd_writeback_back", 1, 28'h08, '0, -1);
        chk("cnt5_miss", 128'(miss_count), 128'(11));
        chk("cnt5_hit", 128'(hit_count), 128'(3));

        // Both request lines high is no request; stray mem_ready is ignored
        cache_read  = 1'b1;
        cache_write = 1'b1;
        cache_addr  = 28'h50;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_cycle();
            chk("both_no_ready", 128'(cache_ready), 128'(0));
        end
        cache_read  = 1'b0;
        cache_write = 1'b0;
        mem_ready   = 1'b1;
        @(negedge clk);
        mem_ready   = 1'b0;
        @(negedge clk);
        chk("stray_no_read", 128'(mem_read), 128'(0));
        chk("stray_no_write", 128'(mem_write), 128'(0));
        chk("both_miss_cnt", 128'(miss_count), 128'(11));
        chk("both_hit_cnt", 128'(hit_count), 128'(3));

        // Counter saturation
        for (int i = 0; i < 14; i++) begin
            rd_q.push_back(dline(1));
            do_req("rd_sat", 1, 28'h08, '0, 1);
        end
        chk("sat_hit", 128'(hit_count), 128'(15));
        for (int t = 1; t <= 5; t++) do_req("wr_sat_set1", 0, ADDR_W'((t << 3) | 1), dline(20 + t), 1);
        chk("sat_miss", 128'(miss_count), 128'(15));
        chk("sat_hit_hold", 128'(hit_count), 128'(15));

        // Reset during FILL drops mem_read at once; the line is not installed
        push_mop(0, 28'h99, '0);
        cache_read = 1'b1;
        cache_addr = 28'h99;
        for (int i = 0; i < 10 && !pending; i++) begin
            @(negedge clk);
            mem_cycle();
        end
        chk("fill_started", 128'(mem_read), 128'(1));
        #2 cache_reset_n = 1'b0;
        #1;
        chk("async_rst_mem_read", 128'(mem_read), 128'(0));
        chk("async_rst_ready", 128'(cache_ready), 128'(0));
        cache_read = 1'b0;
        pending    = 0;
        @(negedge clk);
        cache_reset_n = 1'b1;
        mem_ready     = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 128'(cache_ready), 128'(0));
        chk("post_rst_mem_read", 128'(mem_read), 128'(0));
        chk("post_rst_miss", 128'(miss_count), 128'(0));
        push_mop(0, 28'h99, '0);
        rd_q.push_back(def_line(28'h99));
        do_req("rd_after_rst", 1, 28'h99, '0, 5);
        chk("after_rst_miss", 128'(miss_count), 128'(1));
        chk("after_rst_hit", 128'(hit_count), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
